// File: rtl/pulse_interval_meter.sv
// Purpose : measures clk cycles between rising edges of a synchronized pulse stream.
// Latency : result valid one cycle after the closing edge of an interval.
// Backpres: one-entry holding register; a capture while held and not accepted is dropped and sets sticky miss.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in                synchronized pulse input (rising edge = event)
//   clr               synchronous clear of measurement, result and flags
//   period, ovf       held result; ovf marks a saturated interval (period = 2^W-1)
//   valid, ready      result handshake
//   miss              sticky: a result was dropped under back-pressure
//   min_period,       smallest / largest accepted result since reset or clr
//   max_period        (present only when PIM_MINMAX_EN is defined)
module pulse_interval_meter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in,
    input  logic         clr,
    output logic [W-1:0] period,
    output logic         ovf,
    output logic         valid,
    input  logic         ready,
    output logic         miss
`ifdef PIM_MINMAX_EN
    ,
    output logic [W-1:0] min_period,
    output logic [W-1:0] max_period
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         in_d;
    logic         rise;
    logic         capture;
    logic         load;
    logic         drop;

    // A level held high for several cycles yields a single event.
    assign rise = in & ~in_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (clr) begin
            // clr wins over a coincident edge: that edge neither closes nor opens an interval.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        // Closing edge of this interval is also the opening edge of the next.
                        capture = 1'b1;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The holding register frees up in the same cycle it is handed off.
    assign load = capture & (~valid | ready);
    assign drop = capture & valid & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_d    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            in_d    <= in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
            miss   <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
            miss  <= 1'b0;
        end else begin
            if (load) begin
                period <= cnt_q;
                ovf    <= (cnt_q == CNT_MAX);
                valid  <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (drop) begin
                miss <= 1'b1;
            end
        end
    end

`ifdef PIM_MINMAX_EN
    // Tracks only results that actually entered the holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_period <= CNT_MAX;
            max_period <= '0;
        end else if (clr) begin
            min_period <= CNT_MAX;
            max_period <= '0;
        end else if (load) begin
            if (cnt_q < min_period) min_period <= cnt_q;
            if (cnt_q > max_period) max_period <= cnt_q;
        end
    end
`endif

endmodule
